// File: rtl/inout_pkg.sv
// inout_pkg: shared FSM state encoding and parameter limits for the bidirectional bus controller
package inout_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_TURN, ST_READ} state_t;
  localparam int SYNC_MIN = 1;
  localparam int SYNC_MAX = 4;
  localparam int TURN_MIN = 1;
  localparam int TURN_MAX = 15;
  localparam int CNT_W = 4;
endpackage

// File: rtl/inout_lane.sv
// inout_lane: one output-enable lane of tri-state pad drivers
module inout_lane #(
  parameter int LANE = 8
) (
  inout  wire  [LANE-1:0] pad,
  input  logic [LANE-1:0] d,
  input  logic            oe
);
`ifdef DE10NANO
  altiobuf_bidir #(.width(LANE)) u_buf (
    .datain  (d),
    .oe      ({LANE{oe}}),
    .dataio  (pad),
    .dataout ()
  );
`else
  assign pad = oe ? d : {LANE{1'bz}};
`endif
endmodule

// File: rtl/inout_bus_ctrl.sv
// inout_bus_ctrl: half-duplex pad bus controller with registered drive, turnaround and synchronised reads
module inout_bus_ctrl
  import inout_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 8,
  parameter int SYNC  = 2,
  parameter int TURN  = 1,
  localparam int NL   = WIDTH / LANE
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] io_pin,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NL-1:0]    wr_lane_en,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             driving
);
  if (WIDTH % LANE != 0 || SYNC < SYNC_MIN || SYNC > SYNC_MAX || TURN < TURN_MIN || TURN > TURN_MAX) begin : g_bad_param
    $error("inout_bus_ctrl: illegal WIDTH/LANE/SYNC/TURN");
  end
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q;
  logic [NL-1:0]    oe_q;
  logic [WIDTH-1:0] sync_q [SYNC];
  logic             wr_acc, cnt_zero;
  always_comb begin
    wr_ready = state_q == ST_IDLE || state_q == ST_WRITE;
    rd_ack   = state_q == ST_IDLE && rd_req && !wr_valid;
    wr_acc   = wr_valid && wr_ready;
    cnt_zero = cnt_q == '0;
    busy     = state_q != ST_IDLE;
    driving  = |oe_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) state_d = ST_WRITE;
        else if (rd_req) begin
          state_d = ST_READ;
          cnt_d   = CNT_W'(SYNC - 1);
        end
      end
      ST_WRITE: begin
        if (!wr_valid) begin
          state_d = ST_TURN;
          cnt_d   = CNT_W'(TURN - 1);
        end
      end
      default: begin
        state_d = cnt_zero ? ST_IDLE : state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= wr_acc ? wr_data : out_q;
      oe_q     <= wr_acc ? wr_lane_en : '0;
      rd_valid <= state_q == ST_READ && cnt_zero;
      if (state_q == ST_READ && cnt_zero) rd_data <= sync_q[SYNC-1];
      sync_q[0] <= io_pin;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  for (genvar g = 0; g < NL; g++) begin : g_lane
    inout_lane #(.LANE(LANE)) u_lane (
      .pad (io_pin[g*LANE +: LANE]),
      .d   (out_q[g*LANE +: LANE]),
      .oe  (oe_q[g])
    );
  end
endmodule

// File: tb/tb_inout_bus_ctrl.sv
// tb_inout_bus_ctrl: directed self-checking bench for inout_bus_ctrl (WIDTH=16, LANE=8, SYNC=2, TURN=1)
module tb_inout_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  wire  [15:0] io_pin;
  logic        wr_valid, wr_ready, rd_req, rd_ack, rd_valid, busy, driving;
  logic [15:0] wr_data, rd_data;
  logic [1:0]  wr_lane_en;
  logic [15:0] ext_val, ext_en;
  int          n_chk = 0;
  int          n_fail = 0;
  inout_bus_ctrl #(.WIDTH(16), .LANE(8), .SYNC(2), .TURN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_pin     (io_pin),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_lane_en (wr_lane_en),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .driving    (driving)
  );
  for (genvar i = 0; i < 16; i++) begin : g_ext
    assign io_pin[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (driving !== 1'b0) begin n_fail++; $display("FAIL reset_driving got %b want 0", driving); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_chk++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
  endtask
  task automatic test_write_basic();
    wr_data = 16'hA55A; wr_lane_en = 2'b11; wr_valid = 1'b1;
    #1;
    n_chk++; if (driving !== 1'b0) begin n_fail++; $display("FAIL wr_no_comb_drive got %b want 0", driving); end
    step(); wr_valid = 1'b0;
    n_chk++; if (io_pin !== 16'hA55A) begin n_fail++; $display("FAIL wr_pins got %h want a55a", io_pin); end
    n_chk++; if (driving !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_drive_busy got %b%b want 11", driving, busy); end
    step();
    n_chk++; if (driving !== 1'b0) begin n_fail++; $display("FAIL wr_turn_release got %b want 0", driving); end
    n_chk++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_turn_ready_busy got %b%b want 01", wr_ready, busy); end
    step();
    n_chk++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_back_idle got %b%b want 01", busy, wr_ready); end
  endtask
  task automatic test_lane_mask();
    wr_data = 16'h1234; wr_lane_en = 2'b01; wr_valid = 1'b1;
    ext_val = 16'hC300; ext_en = 16'hFF00;
    step(); wr_valid = 1'b0;
    n_chk++; if (io_pin !== 16'hC334) begin n_fail++; $display("FAIL lane_mask_pins got %h want c334", io_pin); end
    n_chk++; if (driving !== 1'b1) begin n_fail++; $display("FAIL lane_mask_driving got %b want 1", driving); end
    step(); ext_en = 16'h0000;
    step();
    wr_data = 16'hFFFF; wr_lane_en = 2'b00; wr_valid = 1'b1;
    #1;
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL zero_mask_ready got %b want 1", wr_ready); end
    step(); wr_valid = 1'b0;
    n_chk++; if (busy !== 1'b1 || driving !== 1'b0) begin n_fail++; $display("FAIL zero_mask_state got busy %b drv %b want 1 0", busy, driving); end
    step(); step();
  endtask
  task automatic test_back_to_back();
    logic [15:0] seq [3] = '{16'h0001, 16'h0002, 16'h0003};
    wr_lane_en = 2'b11; wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = seq[k];
      #1;
      n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", k, wr_ready); end
      step();
      n_chk++; if (io_pin !== seq[k]) begin n_fail++; $display("FAIL b2b_pins[%0d] got %h want %h", k, io_pin, seq[k]); end
    end
    wr_valid = 1'b0;
    step();
    n_chk++; if (driving !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_turn got drv %b busy %b want 0 1", driving, busy); end
    step();
  endtask
  task automatic test_turnaround_read();
    wr_data = 16'h1111; wr_lane_en = 2'b11; wr_valid = 1'b1; rd_req = 1'b1;
    #1;
    n_chk++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_write_wins got %b want 0", rd_ack); end
    step(); wr_valid = 1'b0;
    n_chk++; if (io_pin !== 16'h1111 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_write_phase got pins %h ack %b want 1111 0", io_pin, rd_ack); end
    step();
    n_chk++; if (driving !== 1'b0 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_turn got drv %b ack %b want 0 0", driving, rd_ack); end
    ext_val = 16'hBEEF; ext_en = 16'hFFFF;
    #1;
    n_chk++; if (io_pin !== 16'hBEEF) begin n_fail++; $display("FAIL rd_ext_bus got %h want beef", io_pin); end
    step();
    n_chk++; if (rd_ack !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_ack_idle got ack %b busy %b want 1 0", rd_ack, busy); end
    step(); rd_req = 1'b0;
    n_chk++; if (busy !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat1 got busy %b valid %b want 1 0", busy, rd_valid); end
    step();
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat2 got %b want 0", rd_valid); end
    step();
    n_chk++; if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_result got valid %b data %h want 1 beef", rd_valid, rd_data); end
    ext_val = 16'h0000;
    step();
    n_chk++; if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_hold got valid %b data %h want 0 beef", rd_valid, rd_data); end
    ext_en = 16'h0000;
  endtask
  task automatic test_reset_abort();
    wr_data = 16'hFFFF; wr_lane_en = 2'b11; wr_valid = 1'b1;
    step(); wr_valid = 1'b0;
    n_chk++; if (driving !== 1'b1) begin n_fail++; $display("FAIL abort_pre_drive got %b want 1", driving); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (driving !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_write got drv %b busy %b want 0 0", driving, busy); end
    #2; rst_n = 1'b1;
    step();
    rd_req = 1'b1;
    step(); rd_req = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_read_entered got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || rd_data !== 16'h0000) begin n_fail++; $display("FAIL abort_read got busy %b data %h want 0 0000", busy, rd_data); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid[%0d] got %b want 0", k, rd_valid); end
    end
  endtask
  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0; wr_lane_en = '0;
    ext_val = '0; ext_en = '0;
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_write_basic();
    test_lane_mask();
    test_back_to_back();
    test_turnaround_read();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
